// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with a start/busy/done handshake.
// One input bit is consumed per cycle. The result registers hold between conversions.
// A result lands in DONE, which is WIDTH+1 cycles after the start cycle.
// Optional macro BCD_LZB_EN adds a registered leading-zero blanking mask `blank`.
module bin2bcd_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
`ifdef BCD_LZB_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned SW = BW + WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   sh_q, sh_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            acc_q, acc_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic [SW-1:0]   adj;
    logic [SW-1:0]   shifted;
    logic            carry;
    logic            ovf_new;

`ifdef BCD_LZB_EN
    logic [DIGITS-1:0] blank_q, blank_d, blank_new;
    logic              all_zero;
`endif

    // Add-3 correction per nibble, then the left shift of the whole {bcd, bin} register.
    always_comb begin
        adj = sh_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (sh_q[WIDTH+4*k +: 4] >= 4'd5) begin
                adj[WIDTH+4*k +: 4] = sh_q[WIDTH+4*k +: 4] + 4'd3;
            end
        end
        shifted = {adj[SW-2:0], 1'b0};
        carry   = adj[SW-1];
        ovf_new = acc_q | carry;
    end

`ifdef BCD_LZB_EN
    // Blank digit k (k >= 1) when it and every higher digit of the final result are zero.
    always_comb begin
        blank_new = '0;
        all_zero  = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            all_zero     = all_zero & (shifted[WIDTH+4*k +: 4] == 4'd0);
            blank_new[k] = all_zero & ~ovf_new;
        end
    end
`endif

    // Next-state and datapath control. The result registers load on the final shift,
    // so the result is visible in DONE.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
`ifdef BCD_LZB_EN
        blank_d = blank_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    sh_d    = {{BW{1'b0}}, bin};
                    cnt_d   = CW'(WIDTH);
                    acc_d   = 1'b0;
                    state_d = StShift;
                end
            end
            StShift: begin
                sh_d  = shifted;
                acc_d = ovf_new;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = shifted[SW-1 -: BW];
                    ovf_d   = ovf_new;
                    done_d  = 1'b1;
`ifdef BCD_LZB_EN
                    blank_d = blank_new;
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers. An asynchronous reset aborts a conversion silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            sh_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef BCD_LZB_EN
            blank_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
`ifdef BCD_LZB_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;
`ifdef BCD_LZB_EN
    assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a 5-digit and a 4-digit instance, with directed vectors.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start5, start4;
    logic [15:0] bin5, bin4;
    logic        busy5, done5, ovf5;
    logic        busy4, done4, ovf4;
    logic [19:0] bcd5;
    logic [15:0] bcd4;
`ifdef BCD_LZB_EN
    logic [4:0]  blank5;
    logic [3:0]  blank4;
`endif

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut5 (
        .clk(clk), .reset_n(reset_n), .start(start5), .bin(bin5),
        .busy(busy5), .done(done5), .bcd(bcd5), .ovf(ovf5)
`ifdef BCD_LZB_EN
        , .blank(blank5)
`endif
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .bin(bin4),
        .busy(busy4), .done(done4), .bcd(bcd4), .ovf(ovf4)
`ifdef BCD_LZB_EN
        , .blank(blank4)
`endif
    );

    typedef struct packed {
        logic [19:0] bcd;
        logic        ovf;
        logic [4:0]  blank;
    } exp_t;

    exp_t q5[$];
    exp_t q4[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [19:0] b, input logic o, input logic [4:0] bl);
        exp_t e;
        e.bcd   = b;
        e.ovf   = o;
        e.blank = bl;
        return e;
    endfunction

    // Monitor: pop and compare on each done pulse of the 5-digit instance.
    always @(negedge clk) begin
        exp_t e;
        if (done5 === 1'b1) begin
            if (q5.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut5 unexpected done: bcd %0h", bcd5);
            end else begin
                e = q5.pop_front();
                chk("dut5 bcd", 32'(bcd5), 32'(e.bcd));
                chk("dut5 ovf", 32'(ovf5), 32'(e.ovf));
`ifdef BCD_LZB_EN
                chk("dut5 blank", 32'(blank5), 32'(e.blank));
`endif
            end
        end
    end

    // Monitor: pop and compare on each done pulse of the 4-digit instance.
    always @(negedge clk) begin
        exp_t e;
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut4 unexpected done: bcd %0h", bcd4);
            end else begin
                e = q4.pop_front();
                chk("dut4 bcd", 32'(bcd4), 32'(e.bcd[15:0]));
                chk("dut4 ovf", 32'(ovf4), 32'(e.ovf));
`ifdef BCD_LZB_EN
                chk("dut4 blank", 32'(blank4), 32'(e.blank[3:0]));
`endif
            end
        end
    end

    // One conversion: optional ignored start pulses at N+3/N+16, optional reset abort at N+abort_at.
    task automatic convert(input bit sel, input logic [15:0] b, input bit push, input exp_t e,
                           input bit pulses, input int abort_at);
        int  done_at   = 0;
        int  busy_cnt  = 0;
        int  done_cnt  = 0;
        logic bz, dn;
        @(negedge clk);
        if (sel) begin
            start4 = 1'b1; bin4 = b;
            if (push) q4.push_back(e);
        end else begin
            start5 = 1'b1; bin5 = b;
            if (push) q5.push_back(e);
        end
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            bz = sel ? busy4 : busy5;
            dn = sel ? done4 : done5;
            if (bz === 1'b1) busy_cnt++;
            if (dn === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            start4 = 1'b0;
            start5 = 1'b0;
            bin4   = 16'hA5A5;
            bin5   = 16'hA5A5;
            if (pulses && (k == 3 || k == 16)) begin
                if (sel) begin start4 = 1'b1; bin4 = 16'd7; end
                else begin start5 = 1'b1; bin5 = 16'd7; end
            end
            if (abort_at != 0 && k == abort_at) begin
                #2 reset_n = 1'b0;
                #1;
                chk("abort busy", 32'(busy5), 32'd0);
                chk("abort done", 32'(done5), 32'd0);
                chk("abort bcd", 32'(bcd5), 32'd0);
                chk("abort ovf", 32'(ovf5), 32'd0);
`ifdef BCD_LZB_EN
                chk("abort blank", 32'(blank5), 32'd0);
`endif
            end
            if (abort_at != 0 && k == abort_at + 2) reset_n = 1'b1;
        end
        if (abort_at == 0) begin
            chk("done latency", 32'(done_at), 32'd17);
            chk("busy cycles", 32'(busy_cnt), 32'd17);
            chk("done pulses", 32'(done_cnt), 32'd1);
        end else begin
            chk("aborted done pulses", 32'(done_cnt), 32'd0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start5  = 1'b0;
        start4  = 1'b0;
        bin5    = '0;
        bin4    = '0;
        repeat (3) @(negedge clk);
        chk("reset busy5", 32'(busy5), 32'd0);
        chk("reset done5", 32'(done5), 32'd0);
        chk("reset bcd5", 32'(bcd5), 32'd0);
        chk("reset ovf5", 32'(ovf5), 32'd0);
        chk("reset busy4", 32'(busy4), 32'd0);
        chk("reset bcd4", 32'(bcd4), 32'd0);
`ifdef BCD_LZB_EN
        chk("reset blank5", 32'(blank5), 32'd0);
`endif
        reset_n = 1'b1;

        convert(1'b0, 16'd0,     1'b1, mk(20'h00000, 1'b0, 5'b11110), 1'b0, 0);
        convert(1'b0, 16'd1234,  1'b1, mk(20'h01234, 1'b0, 5'b10000), 1'b0, 0);
        convert(1'b0, 16'hFFFF,  1'b1, mk(20'h65535, 1'b0, 5'b00000), 1'b0, 0);
        convert(1'b0, 16'd9,     1'b1, mk(20'h00009, 1'b0, 5'b11110), 1'b0, 0);
        convert(1'b0, 16'd4321,  1'b1, mk(20'h04321, 1'b0, 5'b10000), 1'b1, 0);
        convert(1'b0, 16'd999,   1'b0, mk(20'h00000, 1'b0, 5'b00000), 1'b0, 8);
        convert(1'b0, 16'd999,   1'b1, mk(20'h00999, 1'b0, 5'b11000), 1'b0, 0);
        convert(1'b1, 16'd12345, 1'b1, mk(20'h02345, 1'b1, 5'b00000), 1'b0, 0);
        convert(1'b1, 16'd9999,  1'b1, mk(20'h09999, 1'b0, 5'b00000), 1'b0, 0);

        repeat (3) @(negedge clk);
        chk("dut5 queue drained", 32'(q5.size()), 32'd0);
        chk("dut4 queue drained", 32'(q4.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter.
- Sits directly upstream of the 7-segment decoders: each output nibble drives one hexdisplay `hdigit` input, so binary counts and measurements show in decimal on the board displays.
- Start/busy/done handshake; result registered and held between conversions.

Parameters:
- WIDTH, 16, bit width of the binary input (>= 1).
- DIGITS, 5, number of BCD digits produced (>= 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  WIDTH  unsigned binary value; captured on the accepted start cycle.
- busy  output  1  high while a conversion is in progress (states SHIFT and DONE).
- done  output  1  one-cycle pulse when bcd/ovf are updated.
- bcd  output  4*DIGITS  packed BCD result; digit k occupies bits [4k+3:4k], k=0 is the units digit.
- ovf  output  1  high if bin > 10^DIGITS-1; updated together with bcd.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; busy=0, done=0, bcd=0, ovf=0.
  - Internal shift register and counter cleared.
  - Reset asserted mid-conversion aborts it with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → load shift register with {DIGITS*4 zeros, bin}, counter=WIDTH, clear internal ovf accumulator, go to SHIFT.
  - start=0 → stay in IDLE.
- SHIFT, one bit per cycle:
  - First, every BCD nibble >= 5 gets +3 (4-bit add, no carry between nibbles).
  - Then the whole {bcd, bin} register shifts left by 1.
  - A 1 shifted out of the top nibble's MSB sets the ovf accumulator (sticky).
  - Counter decrements; when it reaches 0 after the shift, go to DONE.
- DONE:
  - The bcd output register loads the BCD field and ovf loads the accumulator.
  - done=1 for this cycle only; go to IDLE.
- Latency: start accepted in cycle N → done=1 and new bcd visible in cycle N+WIDTH+1. Throughput is one conversion per WIDTH+2 cycles.
- start while busy=1 is ignored (not queued). bin is don't-care outside the accepted start cycle.
- start held high continuously: back-to-back conversions, each re-sampling bin in IDLE.
- bcd/ovf stay stable from one DONE until the next DONE or reset. Downstream may use bcd combinationally at any time.
- Overflow: bcd holds bin mod 10^DIGITS, with every nibble in 0..9; ovf=1.
- Every output nibble is in 0..9 at all times after reset.

Optional Feature:
- Macro: BCD_LZB_EN.
- Defined:
  - Extra output port `blank` (output, DIGITS bits), registered with bcd in DONE, reset value 0.
  - blank[k]=1 when digit k and all higher digits are 0, for k >= 1.
  - blank[0] is always 0, so the units digit is never blanked.
  - When ovf=1, blank is forced to all zeros.
  - Downstream uses blank to force segments off for leading-zero suppression.
- Not defined: no blank port; behaviour otherwise identical.

Test Plan:
1. Reset, then start with bin=0 → done in cycle N+17; bcd=0x00000, ovf=0; with LZB, blank=5'b11110.
2. bin=16'd1234 → bcd=0x01234, ovf=0, busy high for exactly 17 cycles; with LZB, blank=5'b10000.
3. bin=16'hFFFF → bcd=0x65535, ovf=0; then bin=16'd9 → bcd=0x00009. Checks all add-3 paths and that no stale digits remain.
4. start with bin=16'd4321, then pulse start with bin=16'd7 at cycles N+3 and N+16 → ignored; only one done pulse; bcd=0x04321.
5. Assert reset_n=0 at cycle N+8 of a conversion of 16'd999 → busy, done, bcd and ovf are 0 immediately (asynchronously), no done pulse afterwards; next conversion of 16'd999 gives 0x00999.
6. DIGITS=4, bin=16'd12345 → bcd=0x2345, ovf=1; with LZB, blank=4'b0000. Then bin=16'd9999 → bcd=0x9999, ovf=0.
